// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO: one shift-add (mult) or
// restoring shift-subtract (div) step per cycle, then a sign-fix cycle.
module mdu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic [WIDTH-1:0] WD,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0] up_q, up_d;     // product upper half or remainder
  logic [WIDTH-1:0] lw_q, lw_d;     // multiplier/product lower half or quotient
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             in_signed, in_sa, in_sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opb_d   = opb_q;
    up_d    = up_q;
    lw_d    = lw_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    in_signed = ~MDOp[0];
    in_sa     = in_signed & A[WIDTH-1];
    in_sb     = in_signed & B[WIDTH-1];
    abs_a     = in_sa ? -A : A;
    abs_b     = in_sb ? -B : B;

    add_sum = {1'b0, up_q} + {1'b0, opb_q};
    // Shifted remainder needs one extra bit; the extra borrow bit decides restore.
    rem_sh  = {up_q, lw_q[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, opb_q};

    prod = {up_q, lw_q};
    if (~op_q[0] && (sa_q ^ sb_q)) prod = -prod;
    quo = lw_q;
    rem = up_q;
    if (~op_q[0] && (sa_q ^ sb_q)) quo = -quo;
    if (~op_q[0] && sa_q)          rem = -rem;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          op_d    = MDOp;
          sa_d    = in_sa;
          sb_d    = in_sb;
          up_d    = '0;
          cnt_d   = '0;
          opb_d   = MDOp[1] ? abs_b : abs_a;
          lw_d    = MDOp[1] ? abs_a : abs_b;
          state_d = RUN;
        end else begin
          if (HIWrite) hi_d = WD;
          if (LOWrite) lo_d = WD;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          if (!diff[WIDTH+1]) begin
            up_d = diff[WIDTH-1:0];
            lw_d = {lw_q[WIDTH-2:0], 1'b1};
          end else begin
            up_d = rem_sh[WIDTH-1:0];
            lw_d = {lw_q[WIDTH-2:0], 1'b0};
          end
        end else if (lw_q[0]) begin
          up_d = add_sum[WIDTH:1];
          lw_d = {add_sum[0], lw_q[WIDTH-1:1]};
        end else begin
          up_d = {1'b0, up_q[WIDTH-1:1]};
          lw_d = {up_q[0], lw_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opb_q   <= '0;
      up_q    <= '0;
      lw_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opb_q   <= opb_d;
      up_q    <= up_d;
      lw_q    <= lw_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl against an arithmetic HI/LO model.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, Start, HIWrite, LOWrite;
  logic [1:0]  MDOp;
  logic [31:0] A, B, WD;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [31:0] exp_hi, exp_lo;

  mdu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .WD(WD),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the Done cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit wr_with_start, input bit disturb);
    logic [63:0] r;
    int cyc;
    r = ref_mdu(op, a, b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    HIWrite = wr_with_start; LOWrite = wr_with_start; WD = $urandom;
    @(negedge clk);
    Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (disturb && cyc == 5) begin
        Start = 1'b1; HIWrite = 1'b1; LOWrite = 1'b1;
        MDOp = 2'($urandom); A = $urandom; B = $urandom; WD = $urandom;
      end
      if (cyc == 6) begin
        Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
      end
      if (cyc == 10) chk("hold_hilo", {HI, LO}, {exp_hi, exp_lo});
      if (cyc == 20) chk("no_done_run", Done, 1'b0);
      @(negedge clk);
    end
    chk("latency", cyc, 33);
    chk("done_pulse", Done, 1'b1);
    chk("busy_end", Busy, 1'b0);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk("hi", HI, exp_hi);
    chk("lo", LO, exp_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1; Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
    MDOp = '0; A = '0; B = '0; WD = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_hilo", {HI, LO}, 64'd0);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("done_once", Done, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    chk("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    // Back-to-back from here: each Start lands in the previous Done cycle.
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    chk("divu", {HI, LO}, {32'd2, 32'd14});
    do_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0);
    chk("divu_zero", {HI, LO}, {32'd5, 32'hFFFF_FFFF});
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf", {HI, LO}, {32'd0, 32'h8000_0000});
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    do_op(2'b11, 32'd1000, 32'd3, 1'b0, 1'b1);
    chk("divu_disturb", {HI, LO}, {32'd1, 32'd333});
    do_op(2'b01, 32'd12345, 32'd678, 1'b1, 1'b0);

    @(negedge clk);
    HIWrite = 1'b1; WD = 32'h1234;
    @(negedge clk);
    HIWrite = 1'b0; exp_hi = 32'h1234;
    chk("mthi", HI, exp_hi);
    chk("mthi_lo", LO, exp_lo);
    chk("mthi_busy", Busy, 1'b0);
    chk("mthi_done", Done, 1'b0);
    LOWrite = 1'b1; WD = 32'hCAFE_0001;
    @(negedge clk);
    LOWrite = 1'b0; exp_lo = 32'hCAFE_0001;
    chk("mtlo", {HI, LO}, {exp_hi, exp_lo});
    HIWrite = 1'b1; LOWrite = 1'b1; WD = 32'h5A5A_A5A5;
    @(negedge clk);
    HIWrite = 1'b0; LOWrite = 1'b0;
    exp_hi = 32'h5A5A_A5A5; exp_lo = 32'h5A5A_A5A5;
    chk("mt_both", {HI, LO}, {exp_hi, exp_lo});

    Start = 1'b1; MDOp = 2'b01; A = 32'hDEAD_BEEF; B = 32'h1357_9BDF;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_done", Done, 1'b0);
    chk("midrst_hilo", {HI, LO}, 64'd0);
    repeat (30) @(negedge clk);
    chk("midrst_nodone", {Done, Busy}, 2'b00);
    chk("midrst_hold", {HI, LO}, 64'd0);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15)) - 32'd8;
      do_op(op, ra, rb, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide sequencer for the mipsCPU datapath; implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the HI/LO registers and runs one add/sub-and-shift step per cycle through an internal WIDTH-bit adder/subtractor.
- The controller stalls issue while Busy=1; MFHI/MFLO read HI/LO directly.

Parameters:
- WIDTH, 32, operand width and number of iteration steps.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  begin the operation selected by MDOp; sampled only when Busy=0.
- MDOp  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  input  WIDTH  rs operand (multiplicand / dividend).
- B  input  WIDTH  rt operand (multiplier / divisor).
- HIWrite  input  1  MTHI: HI <= WD.
- LOWrite  input  1  MTLO: LO <= WD.
- WD  input  WIDTH  write data for MTHI/MTLO.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse: HI/LO just updated by a mult/div.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, overrides everything, including mid-operation):
  - state=IDLE, Busy=0, Done=0, HI=0, LO=0, step counter=0.
  - An in-flight result is discarded.
- States: IDLE, RUN, FIX.
- IDLE, Start=1, sampled at edge T:
  - Latch MDOp, the sign of each operand (signed ops only) and the absolute values |A|, |B|. Unsigned ops take A and B as-is.
  - Clear the partial result and set cnt=0; next state is RUN, so Busy=1 from the cycle after edge T.
- RUN, one step per edge, WIDTH steps total (edges T+1..T+WIDTH):
  - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand into the upper half. Shift the {upper, lower} pair right by 1, capturing the adder carry.
  - Divide: restoring. Shift {rem, quo} left by 1 and compute rem−divisor. If there is no borrow, rem takes the difference and quo LSB=1; otherwise quo LSB=0.
  - cnt increments each step; at cnt=WIDTH−1 the next state is FIX.
- FIX (edge T+WIDTH+1):
  - Signed mult: negate the 2·WIDTH product if sA≠sB.
  - Signed div: negate the quotient if sA≠sB; negate the remainder if sA=1.
  - Write {HI,LO} = product (mult), or HI=remainder, LO=quotient (div).
  - Next state IDLE; Done=1 for exactly the next cycle; Busy=0 in that same cycle.
- Latency: Busy=1 for WIDTH+1 cycles (33 at default). Results are visible in the cycle following edge T+WIDTH+1. A new Start is accepted back-to-back in the Done cycle.
- HI/LO hold their old values throughout RUN and FIX; there are no partial updates.
- Divide by zero: no trap, fixed latency.
  - DIVU: LO=all ones, HI=A.
  - DIV: LO=all ones if A≥0, LO=1 if A<0; HI=A.
  - These values are the natural result of the algorithm plus the sign fix.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Concurrent requests:
  - Start, HIWrite and LOWrite while Busy=1 are ignored; the controller must stall instead.
  - In IDLE, Start together with HIWrite/LOWrite: Start wins and the write is dropped.
  - HIWrite and LOWrite together (no Start): both registers are written with WD.
- MTHI/MTLO take effect at the sampling edge: HI/LO show WD next cycle. They do not assert Busy or Done.
- Done stays 0 except for the single post-FIX cycle.

Test Plan:
- Reset, then MULTU A=0xFFFFFFFF, B=0xFFFFFFFF:
  - Busy=1 for 33 cycles, then Done pulses for 1 cycle.
  - HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (−3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21).
- DIV A=−7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=5, same 33-cycle latency.
- DIV 0x80000000 / −1 -> LO=0x80000000, HI=0.
- MTHI WD=0x1234 with HIWrite=1 in IDLE -> HI=0x1234 next cycle, no Busy.
- Start DIVU; during RUN pulse HIWrite and Start -> both ignored, final result unchanged.
- Start MULTU; assert reset at cycle 10 -> next cycle Busy=0, HI=LO=0, no Done pulse.
- Back-to-back ops: Start asserted in the Done cycle is accepted.
